// File: rtl/llc_pipe_fifo_hazard_pkg.sv
// Shared constants and helpers for the LLC inter-stage FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package llc_pipe_fifo_hazard_pkg;

  // Default width of the cache set index carried alongside each stage packet.
  localparam int LLC_SET_BITS = 8;

  // Advance a circular-buffer pointer, wrapping explicitly from depth-1 to 0
  // so that non-power-of-two depths wrap correctly.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/llc_pipe_fifo_hazard_if.sv
// Bundle of control, payload, status and hazard-query signals for one LLC stage FIFO.
// Latency: n/a (wires only).
// Backpressure: producer must honour full; pop on empty is flagged, not blocked.
interface llc_pipe_fifo_hazard_if
  import llc_pipe_fifo_hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = LLC_SET_BITS,
  parameter int CNT_BITS   = 3
);
  logic                  flush;
  logic                  err_clr;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic [SET_BITS-1:0]   set_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic [SET_BITS-1:0]   set_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [CNT_BITS-1:0]   usage;
  logic                  chk_valid;
  logic [SET_BITS-1:0]   chk_set;
  logic                  hazard;
  logic                  err_overflow;
  logic                  err_underflow;

  // Stage logic around the FIFO (producer, consumer and hazard querier).
  modport master (
    output flush, err_clr, push, data_in, set_in, pop, chk_valid, chk_set,
    input  data_out, set_out, valid_out, full, empty, almost_full, usage,
           hazard, err_overflow, err_underflow
  );

  // The FIFO itself.
  modport slave (
    input  flush, err_clr, push, data_in, set_in, pop, chk_valid, chk_set,
    output data_out, set_out, valid_out, full, empty, almost_full, usage,
           hazard, err_overflow, err_underflow
  );
endinterface

// File: rtl/llc_set_match.sv
// Set-conflict matcher: asserts when the key equals the set of any valid entry.
// Latency: combinational.
// Backpressure: none; pure compare and OR-reduce.
module llc_set_match #(
  parameter int DEPTH    = 4,
  parameter int SET_BITS = 8
) (
  input  logic [DEPTH-1:0]               vld_i,
  input  logic [DEPTH-1:0][SET_BITS-1:0] set_i,
  input  logic [SET_BITS-1:0]            key_i,
  output logic                           match_o
);
  logic [DEPTH-1:0] hit;

  // One comparator per entry, qualified by that entry's valid bit.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = vld_i[i] && (set_i[i] == key_i);
    end
  end

  assign match_o = |hit;
endmodule

// File: rtl/llc_pipe_fifo_hazard.sv
// Inter-stage LLC FIFO with flush, almost-full, sticky errors and set-conflict check.
// Latency: 1 cycle write-to-read (first-word fall-through head); hazard is combinational.
// Backpressure: push dropped when full unless popped same cycle; pop on empty rejected.
module llc_pipe_fifo_hazard
  import llc_pipe_fifo_hazard_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int SET_BITS     = LLC_SET_BITS,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter int HAZ_BYPASS   = 1,
  parameter int CNT_BITS     = $clog2(DEPTH + 1)
) (
  input logic                   clk,
  input logic                   rst,
  llc_pipe_fifo_hazard_if.slave fif
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
  logic [CNT_BITS-1:0]            usage_q, usage_d;
  logic [DEPTH-1:0]               vld_q, vld_d;
  logic [DEPTH-1:0][SET_BITS-1:0] set_q;
  logic [DATA_WIDTH-1:0]          data_q [DEPTH];
  logic                           ovf_q, ovf_d;
  logic                           udf_q, udf_d;

  logic full, empty;
  logic push_ok, pop_ok;
  logic ovf_set, udf_set;
  logic stored_hit, bypass_hit;

  // Status comes only from registered occupancy, never from push/pop.
  assign full  = (usage_q == CNT_BITS'(DEPTH));
  assign empty = (usage_q == '0);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = !fif.flush && fif.push && (!full || fif.pop);
  assign pop_ok  = !fif.flush && fif.pop && !empty;
  assign ovf_set = !fif.flush && fif.push && full && !fif.pop;
  assign udf_set = !fif.flush && fif.pop && empty;

  // Pointer, occupancy and per-entry valid next state; flush overrides push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    usage_d  = usage_q;
    vld_d    = vld_q;
    if (fif.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      usage_d  = '0;
      vld_d    = '0;
    end else begin
      // Pop clears before push sets, so a full replace leaves the slot valid.
      if (pop_ok) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = PTR_W'(ptr_next(int'(rd_ptr_q), DEPTH));
      end
      if (push_ok) begin
        vld_d[wr_ptr_q] = 1'b1;
        wr_ptr_d        = PTR_W'(ptr_next(int'(wr_ptr_q), DEPTH));
      end
      if (push_ok && !pop_ok) begin
        usage_d = usage_q + CNT_BITS'(1);
      end else if (pop_ok && !push_ok) begin
        usage_d = usage_q - CNT_BITS'(1);
      end
    end
  end

  // Sticky error flags; clear wins over a same-cycle set.
  always_comb begin
    ovf_d = fif.err_clr ? 1'b0 : (ovf_q | ovf_set);
    udf_d = fif.err_clr ? 1'b0 : (udf_q | udf_set);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
      vld_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      usage_q  <= usage_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Payload and set storage; contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_q[wr_ptr_q] <= fif.data_in;
      set_q[wr_ptr_q]  <= fif.set_in;
    end
  end

  // Entries being popped this cycle are still in flight for the conflict check.
  llc_set_match #(
    .DEPTH    (DEPTH),
    .SET_BITS (SET_BITS)
  ) u_set_match (
    .vld_i   (vld_q),
    .set_i   (set_q),
    .key_i   (fif.chk_set),
    .match_o (stored_hit)
  );

  assign bypass_hit = (HAZ_BYPASS != 0) && push_ok && (fif.set_in == fif.chk_set);

  assign fif.hazard        = fif.chk_valid && (stored_hit || bypass_hit);
  assign fif.data_out      = empty ? '0 : data_q[rd_ptr_q];
  assign fif.set_out       = empty ? '0 : set_q[rd_ptr_q];
  assign fif.valid_out     = !empty;
  assign fif.full          = full;
  assign fif.empty         = empty;
  assign fif.almost_full   = (usage_q >= CNT_BITS'(AFULL_THRESH));
  assign fif.usage         = usage_q;
  assign fif.err_overflow  = ovf_q;
  assign fif.err_underflow = udf_q;
endmodule

// File: tb/tb_llc_pipe_fifo_hazard.sv
// Scoreboard bench: two FIFOs (depth 4 with bypass, depth 3 without) get identical stimulus.
// Latency: checks hazard/head before each edge, status one time unit after it.
// Backpressure: the reference queue decides acceptance independently of the DUT.
module tb_llc_pipe_fifo_hazard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  llc_pipe_fifo_hazard_if #(.DATA_WIDTH(32), .SET_BITS(8), .CNT_BITS(3)) ifa ();
  llc_pipe_fifo_hazard_if #(.DATA_WIDTH(32), .SET_BITS(8), .CNT_BITS(2)) ifb ();

  llc_pipe_fifo_hazard #(
    .DATA_WIDTH(32), .DEPTH(4), .SET_BITS(8), .AFULL_THRESH(3), .HAZ_BYPASS(1)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .fif (ifa.slave)
  );

  llc_pipe_fifo_hazard #(
    .DATA_WIDTH(32), .DEPTH(3), .SET_BITS(8), .AFULL_THRESH(2), .HAZ_BYPASS(0)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .fif (ifb.slave)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic [7:0]  set;
    logic        vld;
    logic        full;
    logic        empty;
    logic        af;
    logic [2:0]  usg;
    logic        haz;
    logic        ovf;
    logic        udf;
  } obs_t;

  int    n_vec = 0;
  int    n_err = 0;
  string dn [2]      = '{"a", "b"};
  int    mdepth [2]  = '{4, 3};
  int    mafull [2]  = '{3, 2};
  bit    mbyp [2]    = '{1'b1, 1'b0};
  bit    movf [2];
  bit    mudf [2];
  logic [39:0] mq [2][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.dat = ifa.data_out;  o.set = ifa.set_out;  o.vld = ifa.valid_out;
      o.full = ifa.full;     o.empty = ifa.empty;  o.af = ifa.almost_full;
      o.usg = ifa.usage;     o.haz = ifa.hazard;
      o.ovf = ifa.err_overflow; o.udf = ifa.err_underflow;
    end else begin
      o.dat = ifb.data_out;  o.set = ifb.set_out;  o.vld = ifb.valid_out;
      o.full = ifb.full;     o.empty = ifb.empty;  o.af = ifb.almost_full;
      o.usg = {1'b0, ifb.usage}; o.haz = ifb.hazard;
      o.ovf = ifb.err_overflow; o.udf = ifb.err_underflow;
    end
    return o;
  endfunction

  task automatic drive(input bit fl, input bit ec, input bit ps, input bit pp, input bit cv,
                       input logic [7:0] cs, input logic [7:0] sin, input logic [31:0] din);
    ifa.flush = fl; ifa.err_clr = ec; ifa.push = ps; ifa.pop = pp;
    ifa.chk_valid = cv; ifa.chk_set = cs; ifa.set_in = sin; ifa.data_in = din;
    ifb.flush = fl; ifb.err_clr = ec; ifb.push = ps; ifb.pop = pp;
    ifb.chk_valid = cv; ifb.chk_set = cs; ifb.set_in = sin; ifb.data_in = din;
  endtask

  task automatic check_status(input int d);
    obs_t o;
    int   n;
    o = get_obs(d);
    n = mq[d].size();
    check({dn[d], ".usage"}, o.usg, n);
    check({dn[d], ".empty"}, o.empty, n == 0);
    check({dn[d], ".full"}, o.full, n == mdepth[d]);
    check({dn[d], ".almost_full"}, o.af, n >= mafull[d]);
    check({dn[d], ".valid_out"}, o.vld, n != 0);
    check({dn[d], ".data_out"}, o.dat, (n != 0) ? mq[d][0][31:0] : 32'h0);
    check({dn[d], ".set_out"}, o.set, (n != 0) ? mq[d][0][39:32] : 8'h0);
    check({dn[d], ".err_overflow"}, o.ovf, movf[d]);
    check({dn[d], ".err_underflow"}, o.udf, mudf[d]);
  endtask

  // One clock of stimulus: drive after the falling edge, check combinational
  // results just before the rising edge, then check status just after it.
  task automatic step(input bit fl, input bit ec, input bit ps, input bit pp, input bit cv,
                      input logic [7:0] cs, input logic [7:0] sin, input logic [31:0] din);
    obs_t        o;
    bit          is_full, is_empty, pacc, popacc, hz;
    logic [39:0] e;
    @(negedge clk);
    drive(fl, ec, ps, pp, cv, cs, sin, din);
    #1;
    for (int d = 0; d < 2; d++) begin
      o        = get_obs(d);
      is_full  = (mq[d].size() == mdepth[d]);
      is_empty = (mq[d].size() == 0);
      pacc     = !fl && ps && (!is_full || pp);
      popacc   = !fl && pp && !is_empty;
      hz       = 1'b0;
      for (int i = 0; i < mq[d].size(); i++) begin
        if (mq[d][i][39:32] == cs) hz = 1'b1;
      end
      if (mbyp[d] && pacc && (sin == cs)) hz = 1'b1;
      check({dn[d], ".hazard"}, o.haz, cv && hz);
      if (popacc) begin
        e = mq[d].pop_front();
        check({dn[d], ".pop_data"}, o.dat, e[31:0]);
        check({dn[d], ".pop_set"}, o.set, e[39:32]);
      end
      if (fl) mq[d].delete();
      else if (pacc) mq[d].push_back({sin, din});
      if (ec) movf[d] = 1'b0;
      else if (!fl && ps && is_full && !pp) movf[d] = 1'b1;
      if (ec) mudf[d] = 1'b0;
      else if (!fl && pp && is_empty) mudf[d] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_status(d);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 32'h0);
  endtask

  task automatic clr();
    step(0, 1, 0, 0, 0, 8'h00, 8'h00, 32'h0);
  endtask

  task automatic push1(input logic [7:0] s, input logic [31:0] dv);
    step(0, 0, 1, 0, 0, 8'h00, s, dv);
  endtask

  task automatic pop1();
    step(0, 0, 0, 1, 0, 8'h00, 8'h00, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 32'h0);
    #22;
    for (int d = 0; d < 2; d++) begin
      check_status(d);
      check({dn[d], ".rst_hazard"}, get_obs(d).haz, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Fill and drain in order.
    for (int i = 0; i < 4; i++) push1(8'(8'h10 + i), 32'hA000_0010 + i);
    for (int i = 0; i < 4; i++) pop1();
    clr();

    // Pointer wrap.
    for (int i = 0; i < 3; i++) push1(8'(8'h40 + i), 32'hB000_0040 + i);
    for (int i = 0; i < 3; i++) pop1();
    for (int i = 0; i < 4; i++) push1(8'(8'h50 + i), 32'hB000_0050 + i);
    for (int i = 0; i < 4; i++) pop1();
    clr();

    // Full replace, then overflow and clear.
    for (int i = 0; i < 4; i++) push1(8'(8'h60 + i), 32'hC000_0060 + i);
    step(0, 0, 1, 1, 0, 8'h00, 8'h64, 32'hC000_0064);
    push1(8'h65, 32'hC000_0065);
    idle();
    clr();
    idle();
    for (int i = 0; i < 4; i++) pop1();
    clr();

    // Underflow, and push+pop on empty.
    pop1();
    idle();
    clr();
    step(0, 0, 1, 1, 0, 8'h00, 8'h70, 32'hD000_0070);
    pop1();
    clr();

    // Hazard queries; leave an underflow flag set across the flush.
    pop1();
    push1(8'h20, 32'hE000_0020);
    push1(8'h21, 32'hE000_0021);
    step(0, 0, 0, 0, 1, 8'h21, 8'h00, 32'h0);
    step(0, 0, 0, 0, 1, 8'h22, 8'h00, 32'h0);
    step(0, 0, 1, 0, 1, 8'h22, 8'h22, 32'hE000_0022);
    step(0, 0, 0, 0, 1, 8'h22, 8'h00, 32'h0);

    // Flush with push/pop asserted, then query the old sets.
    step(1, 0, 1, 1, 1, 8'h20, 8'h23, 32'hE000_0023);
    step(0, 0, 0, 0, 1, 8'h20, 8'h00, 32'h0);
    step(0, 0, 0, 0, 1, 8'h21, 8'h00, 32'h0);
    clr();

    // Random traffic over a small set range.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'(8'h30 + $urandom_range(0, 3)), 8'(8'h30 + $urandom_range(0, 3)), $urandom());
    end

    // Asynchronous reset in the middle of a burst.
    clr();
    push1(8'h80, 32'hF000_0080);
    push1(8'h81, 32'hF000_0081);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 8'h00, 8'h82, 32'hF000_0082);
    #2;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      movf[d] = 1'b0;
      mudf[d] = 1'b0;
      check_status(d);
      check({dn[d], ".arst_hazard"}, get_obs(d).haz, 1'b0);
    end
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    push1(8'h90, 32'hF000_0090);
    pop1();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
